seq_datapath: RTL and testbench

SEQ_DATAPATH -- requirements
Module: seq_datapath

---
 rtl/seq_datapath.sv | 230 +++++++++++++++++++++++
 tb/tb_seq_datapath.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : seq_datapath
//  Description : Multi-cycle register-file datapath. A started operation
//                loads Y from R[rb], evaluates Z = f(Y, R[rc]) and writes the
//                result back to R[ra] (single-cycle ops) or to HI/LO
//                (iterative unsigned MUL/DIV, DATA_W iteration cycles).
//  Ports       : clk            - clock, rising edge
//                clr            - synchronous active-low reset
//                start/opcode   - operation request and select (IDLE only)
//                ra/rb/rc       - destination / source A / source B addresses
//                ld_en/ld_addr/ld_data - external register preload (IDLE only)
//                rd_addr/rd_data- combinational register read port
//                busy/done/dz   - status (done, dz are one-cycle pulses)
//                hi/lo/y/z      - internal register contents
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_datapath #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                start,
    input  logic [3:0]          opcode,
    input  logic [ADDR_W-1:0]   ra,
    input  logic [ADDR_W-1:0]   rb,
    input  logic [ADDR_W-1:0]   rc,
    input  logic                ld_en,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [DATA_W-1:0]   ld_data,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                busy,
    output logic                done,
    output logic                dz,
    output logic [DATA_W-1:0]   hi,
    output logic [DATA_W-1:0]   lo,
    output logic [DATA_W-1:0]   y,
    output logic [2*DATA_W-1:0] z
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_Y = 3'd1,
        S_EXEC   = 3'd2,
        S_ITER   = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [3:0] c_OP_ADD = 4'd0;
    localparam logic [3:0] c_OP_SUB = 4'd1;
    localparam logic [3:0] c_OP_AND = 4'd2;
    localparam logic [3:0] c_OP_OR  = 4'd3;
    localparam logic [3:0] c_OP_SHL = 4'd4;
    localparam logic [3:0] c_OP_SHR = 4'd5;
    localparam logic [3:0] c_OP_ROL = 4'd6;
    localparam logic [3:0] c_OP_ROR = 4'd7;
    localparam logic [3:0] c_OP_NOT = 4'd8;
    localparam logic [3:0] c_OP_NEG = 4'd9;
    localparam logic [3:0] c_OP_MUL = 4'd10;
    localparam logic [3:0] c_OP_DIV = 4'd11;

    localparam int                CNT_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  c_CNT_INIT = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W:0]   c_NUM_REGS = (ADDR_W+1)'(NUM_REGS);
    localparam logic [DATA_W-1:0] c_DW       = DATA_W'(DATA_W);

    state_t              r_state;
    logic [3:0]          r_op;
    logic [ADDR_W-1:0]   r_ra;
    logic [ADDR_W-1:0]   r_rb;
    logic [ADDR_W-1:0]   r_rc;
    logic [DATA_W-1:0]   r_y;
    logic [2*DATA_W-1:0] r_z;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic                r_done;
    logic                r_dz;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];

    // Addresses beyond the implemented register count read as zero and
    // swallow writes.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < c_NUM_REGS);
    endfunction

    logic [DATA_W-1:0]   w_src_b;
    logic [DATA_W-1:0]   w_src_c;
    logic [DATA_W-1:0]   w_shamt;
    logic [DATA_W-1:0]   w_shinv;
    logic [DATA_W-1:0]   w_alu;
    logic                w_is_iter;
    logic [DATA_W:0]     w_mul_sum;
    logic [2*DATA_W-1:0] w_mul_next;
    logic [DATA_W:0]     w_rem_sh;
    logic [DATA_W-1:0]   w_rem_sub;
    logic                w_rem_ge;
    logic [2*DATA_W-1:0] w_div_next;

    assign w_src_b  = addr_ok(r_rb)    ? r_regs[r_rb]    : '0;
    assign w_src_c  = addr_ok(r_rc)    ? r_regs[r_rc]    : '0;
    assign rd_data  = addr_ok(rd_addr) ? r_regs[rd_addr] : '0;

    // Shift count is taken modulo DATA_W; a zero count makes the
    // complementary rotate shift equal DATA_W, which yields zero.
    assign w_shamt  = w_src_c % c_DW;
    assign w_shinv  = c_DW - w_shamt;

    assign w_is_iter = (r_op == c_OP_MUL) || (r_op == c_OP_DIV);

    always_comb begin
        w_alu = r_y + w_src_c;
        case (r_op)
            c_OP_ADD: w_alu = r_y + w_src_c;
            c_OP_SUB: w_alu = r_y - w_src_c;
            c_OP_AND: w_alu = r_y & w_src_c;
            c_OP_OR:  w_alu = r_y | w_src_c;
            c_OP_SHL: w_alu = r_y << w_shamt;
            c_OP_SHR: w_alu = r_y >> w_shamt;
            c_OP_ROL: w_alu = (r_y << w_shamt) | (r_y >> w_shinv);
            c_OP_ROR: w_alu = (r_y >> w_shamt) | (r_y << w_shinv);
            c_OP_NOT: w_alu = ~w_src_c;
            c_OP_NEG: w_alu = ~w_src_c + 1'b1;
            default:  w_alu = r_y + w_src_c;
        endcase
    end

    // Shift-add multiply: Z low half starts as the multiplier; each step
    // conditionally adds Y into the high half and shifts the whole of Z right.
    assign w_mul_sum  = {1'b0, r_z[2*DATA_W-1:DATA_W]} + (r_z[0] ? {1'b0, r_y} : '0);
    assign w_mul_next = {w_mul_sum, r_z[DATA_W-1:1]};

    // Restoring divide: Z = {remainder, dividend/quotient}. Each step shifts
    // one dividend bit into the remainder and shifts in a quotient bit. A zero
    // divisor always "subtracts", giving all-ones quotient and remainder = Y.
    assign w_rem_sh   = {r_z[2*DATA_W-1:DATA_W], r_z[DATA_W-1]};
    assign w_rem_sub  = w_rem_sh[DATA_W-1:0] - w_src_c;
    assign w_rem_ge   = (w_rem_sh >= {1'b0, w_src_c});
    assign w_div_next = {(w_rem_ge ? w_rem_sub : w_rem_sh[DATA_W-1:0]),
                         r_z[DATA_W-2:0], w_rem_ge};

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_ra    <= '0;
            r_rb    <= '0;
            r_rc    <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_cnt   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A preload in the start cycle lands before LOAD_Y reads.
                    if (ld_en && addr_ok(ld_addr)) begin
                        r_regs[ld_addr] <= ld_data;
                    end
                    if (start) begin
                        r_op    <= opcode;
                        r_ra    <= ra;
                        r_rb    <= rb;
                        r_rc    <= rc;
                        r_state <= S_LOAD_Y;
                    end
                end
                S_LOAD_Y: begin
                    r_y     <= w_src_b;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (r_op == c_OP_MUL) begin
                        r_z     <= {{DATA_W{1'b0}}, w_src_c};
                        r_cnt   <= c_CNT_INIT;
                        r_state <= S_ITER;
                    end else if (r_op == c_OP_DIV) begin
                        r_z     <= {{DATA_W{1'b0}}, r_y};
                        r_cnt   <= c_CNT_INIT;
                        r_state <= S_ITER;
                    end else begin
                        r_z     <= {{DATA_W{1'b0}}, w_alu};
                        r_state <= S_WB;
                    end
                end
                S_ITER: begin
                    r_z <= (r_op == c_OP_MUL) ? w_mul_next : w_div_next;
                    if (r_cnt == '0) begin
                        r_state <= S_WB;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_WB: begin
                    if (w_is_iter) begin
                        r_lo <= r_z[DATA_W-1:0];
                        r_hi <= r_z[2*DATA_W-1:DATA_W];
                        r_dz <= (r_op == c_OP_DIV) && (w_src_c == '0);
                    end else if (addr_ok(r_ra)) begin
                        r_regs[r_ra] <= r_z[DATA_W-1:0];
                    end
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign dz   = r_dz;
    assign hi   = r_hi;
    assign lo   = r_lo;
    assign y    = r_y;
    assign z    = r_z;

endmodule
`default_nettype wire

// File: tb/tb_seq_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_datapath
//  Description : Directed self-checking bench for seq_datapath. Built with
//                NUM_REGS=12 so that out-of-range addresses can be exercised.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_datapath;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          clr;
    logic          start;
    logic [3:0]    opcode;
    logic [AW-1:0] ra, rb, rc;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy, done, dz;
    logic [DW-1:0] hi, lo, y;
    logic [2*DW-1:0] z;

    int n_cmp = 0;
    int n_err = 0;

    seq_datapath #(.DATA_W(DW), .NUM_REGS(12), .ADDR_W(AW)) dut (
        .clk(clk), .clr(clr), .start(start), .opcode(opcode),
        .ra(ra), .rb(rb), .rc(rc),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .dz(dz),
        .hi(hi), .lo(lo), .y(y), .z(z)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic read_reg(input logic [AW-1:0] a, output logic [DW-1:0] v);
        rd_addr = a;
        #1;
        v = rd_data;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    // Issues one operation; returns edges from start edge to done, number of
    // sampled busy cycles and dz seen with done. Optionally preloads in the
    // start cycle, and optionally pokes start/ld_en during the first busy cycle.
    task automatic run_op(input logic [3:0] op, input logic [AW-1:0] a_ra,
                          input logic [AW-1:0] a_rb, input logic [AW-1:0] a_rc,
                          input bit do_ld, input logic [AW-1:0] la,
                          input logic [DW-1:0] ldv, input bit intrude,
                          output int lat, output int busy_cyc, output logic dz_seen);
        @(negedge clk);
        start = 1'b1; opcode = op; ra = a_ra; rb = a_rb; rc = a_rc;
        ld_en = do_ld; ld_addr = la; ld_data = ldv;
        @(posedge clk);
        #1;
        if (intrude) begin
            start = 1'b1; opcode = 4'd1; ra = 4'd7;
            ld_en = 1'b1; ld_addr = 4'd7; ld_data = 32'd77;
        end else begin
            start = 1'b0; ld_en = 1'b0;
        end
        lat = 0;
        busy_cyc = busy ? 1 : 0;
        dz_seen = 1'b0;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            start = 1'b0; ld_en = 1'b0;
            lat++;
            if (busy) busy_cyc++;
            if (done) dz_seen = dz;
        end
        if (lat >= 200) check("done_timeout", 64'(lat), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] v;
        int lat, bc, dcnt;
        logic dzs;

        clr = 1'b0; start = 1'b0; opcode = '0; ra = '0; rb = '0; rc = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_z", z, 64'd0);
        @(negedge clk);
        clr = 1'b1;

        // ADD with latency and busy width
        load(4'd1, 32'd5);
        read_reg(4'd1, v); check("ld_visible", 64'(v), 64'd5);
        load(4'd2, 32'd7);
        run_op(4'd0, 4'd3, 4'd1, 4'd2, 0, 0, 0, 0, lat, bc, dzs);
        check("add_lat", 64'(lat), 64'd3);
        check("add_busy", 64'(bc), 64'd3);
        read_reg(4'd3, v); check("add_r3", 64'(v), 64'd12);
        check("add_y", 64'(y), 64'd5);

        // SUB wrap
        load(4'd1, 32'd0);
        load(4'd2, 32'd1);
        run_op(4'd1, 4'd4, 4'd1, 4'd2, 0, 0, 0, 0, lat, bc, dzs);
        read_reg(4'd4, v); check("sub_r4", 64'(v), 64'hFFFF_FFFF);
        check("sub_z", z, 64'h0000_0000_FFFF_FFFF);

        // MUL full product
        load(4'd1, 32'hFFFF_FFFF);
        load(4'd2, 32'd2);
        run_op(4'd10, 4'd5, 4'd1, 4'd2, 0, 0, 0, 0, lat, bc, dzs);
        check("mul_lat", 64'(lat), 64'd35);
        check("mul_hi", 64'(hi), 64'd1);
        check("mul_lo", 64'(lo), 64'hFFFF_FFFE);
        read_reg(4'd5, v); check("mul_r5_kept", 64'(v), 64'd0);

        // DIV by zero and normal DIV
        load(4'd1, 32'd100);
        load(4'd2, 32'd0);
        run_op(4'd11, 4'd5, 4'd1, 4'd2, 0, 0, 0, 0, lat, bc, dzs);
        check("div0_lo", 64'(lo), 64'hFFFF_FFFF);
        check("div0_hi", 64'(hi), 64'd100);
        check("div0_dz", 64'(dzs), 64'd1);
        load(4'd2, 32'd7);
        run_op(4'd11, 4'd5, 4'd1, 4'd2, 0, 0, 0, 0, lat, bc, dzs);
        check("div_lo", 64'(lo), 64'd14);
        check("div_hi", 64'(hi), 64'd2);
        check("div_dz", 64'(dzs), 64'd0);
        check("div_lat", 64'(lat), 64'd35);

        // Shifts and rotates; count 33 mod 32 = 1
        load(4'd1, 32'h8000_0001);
        load(4'd2, 32'd33);
        run_op(4'd4, 4'd6, 4'd1, 4'd2, 0, 0, 0, 0, lat, bc, dzs);
        read_reg(4'd6, v); check("shl", 64'(v), 64'h0000_0002);
        run_op(4'd5, 4'd6, 4'd1, 4'd2, 0, 0, 0, 0, lat, bc, dzs);
        read_reg(4'd6, v); check("shr", 64'(v), 64'h4000_0000);
        run_op(4'd6, 4'd6, 4'd1, 4'd2, 0, 0, 0, 0, lat, bc, dzs);
        read_reg(4'd6, v); check("rol", 64'(v), 64'h0000_0003);
        run_op(4'd7, 4'd6, 4'd1, 4'd2, 0, 0, 0, 0, lat, bc, dzs);
        read_reg(4'd6, v); check("ror", 64'(v), 64'hC000_0000);
        run_op(4'd8, 4'd6, 4'd1, 4'd2, 0, 0, 0, 0, lat, bc, dzs);
        read_reg(4'd6, v); check("not", 64'(v), 64'hFFFF_FFDE);
        run_op(4'd9, 4'd6, 4'd1, 4'd2, 0, 0, 0, 0, lat, bc, dzs);
        read_reg(4'd6, v); check("neg", 64'(v), 64'hFFFF_FFDF);
        load(4'd2, 32'd32);
        run_op(4'd6, 4'd6, 4'd1, 4'd2, 0, 0, 0, 0, lat, bc, dzs);
        read_reg(4'd6, v); check("rol_by_32", 64'(v), 64'h8000_0001);

        // Logic ops and reserved opcode acting as ADD
        load(4'd1, 32'hF0F0_00FF);
        load(4'd2, 32'h0FF0_0F0F);
        run_op(4'd2, 4'd6, 4'd1, 4'd2, 0, 0, 0, 0, lat, bc, dzs);
        read_reg(4'd6, v); check("and", 64'(v), 64'h00F0_000F);
        run_op(4'd3, 4'd6, 4'd1, 4'd2, 0, 0, 0, 0, lat, bc, dzs);
        read_reg(4'd6, v); check("or", 64'(v), 64'hFFF0_0FFF);
        run_op(4'd13, 4'd6, 4'd1, 4'd2, 0, 0, 0, 0, lat, bc, dzs);
        read_reg(4'd6, v); check("op13_add", 64'(v), 64'h00E0_100E);
        check("op13_z", z, 64'h0000_0000_00E0_100E);

        // Out-of-range addresses (NUM_REGS=12)
        load(4'd13, 32'd5);
        read_reg(4'd13, v); check("oor_ld", 64'(v), 64'd0);
        load(4'd1, 32'd40);
        run_op(4'd0, 4'd14, 4'd1, 4'd13, 0, 0, 0, 0, lat, bc, dzs);
        check("oor_src_z", z, 64'd40);
        read_reg(4'd14, v); check("oor_wb", 64'(v), 64'd0);

        // Reset during MUL iteration, overriding ld_en and start
        load(4'd1, 32'd3);
        load(4'd2, 32'd5);
        @(negedge clk);
        start = 1'b1; opcode = 4'd10; ra = 4'd0; rb = 4'd1; rc = 4'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        clr = 1'b0; start = 1'b1; ld_en = 1'b1; ld_addr = 4'd3; ld_data = 32'd44;
        @(posedge clk);
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_y", 64'(y), 64'd0);
        check("abort_z", z, 64'd0);
        read_reg(4'd1, v); check("abort_r1", 64'(v), 64'd0);
        read_reg(4'd3, v); check("abort_ld", 64'(v), 64'd0);
        @(negedge clk);
        clr = 1'b1; start = 1'b0; ld_en = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) dcnt++;
        end
        check("abort_no_done", 64'(dcnt), 64'd0);

        // Same-cycle preload + start, then intrusion while busy
        run_op(4'd0, 4'd1, 4'd1, 4'd1, 1, 4'd1, 32'd9, 1, lat, bc, dzs);
        read_reg(4'd1, v); check("ldstart_r1", 64'(v), 64'd18);
        check("intrude_lat", 64'(lat), 64'd3);
        read_reg(4'd7, v); check("intrude_ld", 64'(v), 64'd0);
        @(posedge clk);
        #1;
        check("intrude_idle", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
